// File: rtl/acc_share_sched_if.sv
// Request/result bundle for the shared product accumulator.
// master = scheduler side, slave = requesters + result consumer.
interface acc_share_sched_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 16,
  parameter int AW    = 32
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    grant;
  logic                res_valid;
  logic [AW-1:0]       res_data;
  logic [IDW-1:0]      res_id;
  logic                res_ready;
  logic                busy;

  modport master (
    input  req_valid, req_data, res_ready,
    output req_ready, grant, res_valid, res_data, res_id, busy
  );

  modport slave (
    output req_valid, req_data, res_ready,
    input  req_ready, grant, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/acc_share_sched.sv
// Round-robin shared accumulator: 1 arb cycle + BURST beats + result until res_ready.
// Non-owners see req_ready=0; a stalled owner keeps the grant; result held under back-pressure.
module acc_share_sched #(
  parameter int N_REQ = 4,
  parameter int DW    = 16,
  parameter int AW    = 32,
  parameter int BURST = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  acc_share_sched_if.master  bus
);
  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(BURST + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  state_t          r_state, w_state_nxt;
  logic [IDW-1:0]  r_owner, r_last, w_win;
  logic [AW-1:0]   r_acc, r_res_data, w_sum;
  logic [CW-1:0]   r_cnt;
  logic            r_res_valid;
  logic [IDW-1:0]  r_res_id;
  logic            w_any, w_own_vld, w_xfer, w_last_beat;
  logic [DW-1:0]   w_own_dat;
  logic [N_REQ-1:0] w_grant;
  int              w_idx;

  // search starts just after the last completed owner, wrapping to 0
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = (int'(r_last) + k) % N_REQ;
      if (!w_any && bus.req_valid[IDW'(w_idx)]) begin
        w_any = 1'b1;
        w_win = IDW'(w_idx);
      end
    end
  end

  always_comb begin
    w_own_vld = 1'b0;
    w_own_dat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == IDW'(i)) begin
        w_own_vld = bus.req_valid[i];
        w_own_dat = bus.req_data[i*DW +: DW];
      end
    end
  end

  assign w_xfer      = (r_state == S_ACC) && w_own_vld;
  assign w_last_beat = w_xfer && (r_cnt == CW'(BURST - 1));
  assign w_sum       = r_acc + AW'(w_own_dat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any)         w_state_nxt = S_ACC;
      S_ACC:   if (w_last_beat)   w_state_nxt = S_OUT;
      S_OUT:   if (bus.res_ready) w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  // grant and req_ready are decoded from registered state only
  always_comb begin
    w_grant = '0;
    for (int i = 0; i < N_REQ; i++)
      w_grant[i] = (r_state == S_ACC) && (r_owner == IDW'(i));
  end

  assign bus.grant     = w_grant;
  assign bus.req_ready = w_grant;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_id    = r_res_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= '0;
      r_last      <= IDW'(N_REQ - 1);
      r_acc       <= '0;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_win;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_ACC: begin
          if (w_xfer) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CW'(1);
          end
          if (w_last_beat) begin
            r_res_data  <= w_sum;
            r_res_id    <= r_owner;
            r_res_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_last      <= r_owner;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_share_sched.sv
// Directed bench for acc_share_sched: burst sum, fairness, width, stall/back-pressure, async reset.
module tb_acc_share_sched;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  acc_share_sched_if #(.N_REQ(4), .DW(16), .AW(32)) bus ();

  acc_share_sched #(.N_REQ(4), .DW(16), .AW(32), .BURST(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_lane(input int i, input logic [15:0] v);
    bus.req_data[i*16 +: 16] = v;
  endtask

  initial begin
    int cyc0, prev, found, nonown, bad, unstable;

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;
    #12;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_grant",     bus.grant,     0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data",  bus.res_data,  0);
    chk("rst_res_id",    bus.res_id,    0);
    chk("rst_busy",      bus.busy,      0);
    rst_n = 1'b1;

    // single requester 2 sends 1..8
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b0100;
    set_lane(2, 16'd1);
    cyc0 = cyc;
    tick();
    chk("t1_grant",     bus.grant,     4'b0100);
    chk("t1_req_ready", bus.req_ready, 4'b0100);
    chk("t1_busy",      bus.busy,      1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      set_lane(2, 16'(k));
    end
    chk("t1_no_early_res", bus.res_valid, 0);
    tick();
    chk("t1_res_valid", bus.res_valid, 1);
    chk("t1_res_data",  bus.res_data,  36);
    chk("t1_res_id",    bus.res_id,    2);
    chk("t1_grant_out", bus.grant,     0);
    bus.req_valid = '0;
    tick();
    chk("t1_res_valid_drop", bus.res_valid, 0);
    chk("t1_idle",           bus.busy,      0);
    chk("t1_cycles",         cyc - cyc0,    10);

    // fairness from a fresh reset: ids 0,1,2,3,0
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_data  = {4{16'h0001}};
    prev   = cyc;
    nonown = 0;
    for (int g = 0; g < 5; g++) begin
      found = 0;
      for (int t = 0; t < 20 && found == 0; t++) begin
        tick();
        if ((bus.req_ready & ~bus.grant) != 0) nonown++;
        if (bus.res_valid) found = 1;
      end
      chk("t2_result_seen", found, 1);
      chk("t2_res_id",   bus.res_id,   g % 4);
      chk("t2_res_data", bus.res_data, 8);
      if (g > 0) chk("t2_period", cyc - prev, 10);
      prev = cyc;
    end
    chk("t2_nonowner_ready", nonown, 0);
    bus.req_valid = '0;
    tick();

    // width: eight 0xFFFF from requester 1
    bus.req_valid = 4'b0010;
    set_lane(1, 16'hFFFF);
    tick();
    chk("t3_grant", bus.grant, 4'b0010);
    repeat (8) tick();
    chk("t3_res_valid", bus.res_valid, 1);
    chk("t3_res_data",  bus.res_data,  32'h0007FFF8);
    chk("t3_res_id",    bus.res_id,    1);
    bus.req_valid = '0;
    tick();

    // owner 2 stalls while 3 waits, then result back-pressure
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b1100;
    set_lane(2, 16'd10);
    set_lane(3, 16'h0100);
    tick();
    chk("t4_grant", bus.grant, 4'b0100);
    repeat (3) tick();
    bus.req_valid = 4'b1000;
    bad = 0;
    repeat (5) begin
      tick();
      if (bus.grant != 4'b0100 || bus.req_ready != 4'b0100) bad++;
    end
    chk("t4_grant_held", bad, 0);
    chk("t4_no_res_in_stall", bus.res_valid, 0);
    bus.req_valid = 4'b1100;
    repeat (5) tick();
    chk("t4_res_valid", bus.res_valid, 1);
    chk("t4_res_data",  bus.res_data,  80);
    chk("t4_res_id",    bus.res_id,    2);
    unstable = 0;
    repeat (4) begin
      tick();
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd80 || bus.res_id !== 2'd2 || bus.busy !== 1'b1)
        unstable++;
    end
    chk("t4_backpressure_stable", unstable, 0);
    bus.res_ready = 1'b1;
    tick();
    chk("t4_release_valid", bus.res_valid, 0);
    chk("t4_release_busy",  bus.busy,      0);
    tick();
    chk("t4_next_owner", bus.grant, 4'b1000);

    // reset after 3 transfers of owner 3
    set_lane(3, 16'd5);
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("t5_grant",     bus.grant,     0);
    chk("t5_req_ready", bus.req_ready, 0);
    chk("t5_busy",      bus.busy,      0);
    chk("t5_res_valid", bus.res_valid, 0);
    chk("t5_res_data",  bus.res_data,  0);
    chk("t5_res_id",    bus.res_id,    0);
    #1 rst_n = 1'b1;
    bus.req_valid = 4'b1001;
    set_lane(0, 16'd2);
    tick();
    chk("t5_owner0", bus.grant, 4'b0001);
    repeat (8) tick();
    chk("t5_res_valid", bus.res_valid, 1);
    chk("t5_res_data",  bus.res_data,  16);
    chk("t5_res_id",    bus.res_id,    0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/acc_share_sched.md
# acc_share_sched

Round-robin scheduler that shares one 16→32-bit product accumulator among several multiplier requesters. It grants one requester at a time and accepts a fixed-length burst of products from that requester only. It sums the burst, then presents the tagged sum on a single result port before arbitrating again. It sits between the per-lane multiplier outputs and the downstream result consumer.

## Interface
- N_REQ, 4, number of requesters (≥2)
- DW, 16, product width
- AW, 32, accumulator/result width (must be ≥ DW + clog2(BURST))
- BURST, 8, products per grant (≥1)
- IDW, clog2(N_REQ), requester-id width (derived, not overridable)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester product valid
- req_data  in  N_REQ*DW  products; requester i at bits [i*DW +: DW]
- req_ready  out  N_REQ  per-requester accept
- grant  out  N_REQ  one-hot current owner; all-zero when not in ACC
- res_valid  out  1  result valid
- res_data  out  AW  burst sum
- res_id  out  IDW  index of requester that produced res_data
- res_ready  in  1  consumer accept
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, ACC, OUT. Reset to IDLE.
- **IDLE:**
  - If any req_valid is set, select the winner round-robin, searching from last+1 upward with wrap to 0. `last` is the most recently completed owner and resets to N_REQ-1, so requester 0 has first priority after reset.
  - Register the winner in owner, clear acc and cnt to 0, go to ACC.
  - With no req_valid set, stay in IDLE.
- **ACC:**
  - req_ready[owner]=1; every other req_ready=0. req_ready is decoded from registered state and does not depend on req_valid.
  - A transfer occurs when req_valid[owner] && req_ready[owner].
  - On a transfer: acc <= acc + zero-extended req_data[owner]; cnt <= cnt+1.
  - On the transfer with cnt==BURST-1: load res_data with the final sum, set res_id=owner and res_valid=1, go to OUT.
  - If req_valid[owner] is low, hold (no timeout); the grant is not revoked.
  - req_valid from non-owners is ignored and they see req_ready=0.
- **OUT:**
  - Hold res_valid, res_data and res_id stable until res_ready.
  - On res_valid && res_ready: res_valid <= 0, last <= owner, go to IDLE.
- **Arithmetic:** unsigned; the sum wraps modulo 2^AW (cannot overflow when the AW rule holds).
- **Reset values:** req_ready=0, grant=0, res_valid=0, res_data=0, res_id=0, busy=0. Internal: acc=0, cnt=0, owner=0, last=N_REQ-1.
- **Reset mid-burst** (async, any state): the partial sum is discarded, no result is emitted, and the round-robin pointer returns to its reset value.

## Timing
- IDLE→ACC takes 1 cycle. req_ready[owner] is high in the first ACC cycle.
- With the owner streaming back-to-back, the burst occupies BURST cycles. res_valid rises the cycle after the last transfer.
- Minimum grant-to-grant period: 1 (IDLE) + BURST (ACC) + 1 (OUT, res_ready held high) = BURST+2 cycles.
- res_ready asserted in the same cycle res_valid first rises counts as the handshake. The next IDLE cycle follows immediately.
- A request arriving in OUT waits; it is arbitrated in the following IDLE cycle.
- All outputs are registered or decoded from state registers only, with no input→output combinational paths.

## Test plan
- **Single requester, BURST=8:** requester 2 sends 1,2,…,8 back-to-back with res_ready=1. Required: res_data=36, res_id=2, res_valid high exactly 1 cycle, 10 cycles from first IDLE arbitration to return to IDLE.
- **Fairness:** all 4 requesters hold valid continuously, each sending 0x0001. Required: results in id order 0,1,2,3,0,…, each res_data=8, and req_ready never high for a non-owner.
- **Width:** owner sends eight 0xFFFF. Required: res_data=0x0007FFF8, no truncation.
- **Owner stalls and back-pressure:** owner drops valid for 5 cycles mid-burst while requester 3 is valid. Required: grant unchanged and requester 3 not served early. Then hold res_ready=0 for 4 cycles. Required: res_data and res_id stable, busy=1.
- **Reset mid-burst:** pulse rst_n low after 3 transfers. Required: all outputs return to reset values asynchronously, no res_valid. The next grant goes to requester 0 (if valid) with a fresh sum.
